// File: rtl/gps_synth_pkg.sv
// Shared types for the GPS synthesizer channel path.
// The accel field of doppler_cfg_t exists only when SAT_CHAN_DOPPLER_ACCEL_EN is defined.
package gps_synth_pkg;

    localparam int FREQ_W = 32;
    localparam int GAIN_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } doppler_state_t;

    // Fixed-width profile fields; interval and epoch count travel separately
    // because their widths are set by the instantiating module's parameters.
    typedef struct packed {
        logic        [FREQ_W-1:0] freq;
        logic signed [FREQ_W-1:0] rate;
`ifdef SAT_CHAN_DOPPLER_ACCEL_EN
        logic signed [FREQ_W-1:0] accel;
`endif
        logic        [GAIN_W-1:0] gain;
    } doppler_cfg_t;

endpackage

// File: rtl/sat_chan_doppler_epoch_timer.sv
// Epoch timer: counts clocks up to the latched interval, fires an epoch strobe,
// counts epochs and flags the final one when a nonzero target was programmed.
module epoch_timer #(
    parameter int TICK_W = 16,
    parameter int CNT_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              run,
    input  logic [TICK_W-1:0] interval,
    input  logic [CNT_W-1:0]  epochs,
    output logic              epoch,
    output logic              last
);

    logic [TICK_W-1:0] tick;
    logic [TICK_W-1:0] interval_q;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_inc;
    logic [CNT_W-1:0]  epochs_q;

    assign count_inc = count + CNT_W'(1);
    assign epoch     = run && (tick == interval_q);
    assign last      = epoch && (epochs_q != '0) && (count_inc == epochs_q);

    // Profile timing values are captured only on an accepted profile.
    always_ff @(posedge clk) begin
        if (load) begin
            interval_q <= interval;
            epochs_q   <= epochs;
        end
    end

    // Tick and epoch counters restart on every accepted profile.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            tick  <= '0;
            count <= '0;
        end else if (epoch) begin
            tick  <= '0;
            count <= count_inc;
        end else if (run) begin
            tick  <= tick + TICK_W'(1);
        end
    end

endmodule

// File: rtl/sat_chan_doppler.sv
// Per-channel Doppler/gain controller driving sat_chan enable/freq/gain.
// Optional second-order term enabled by defining SAT_CHAN_DOPPLER_ACCEL_EN.
module sat_chan_doppler
    import gps_synth_pkg::*;
#(
    parameter int TICK_W = 16,
    parameter int CNT_W  = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic        [FREQ_W-1:0] cfg_freq,
    input  logic signed [FREQ_W-1:0] cfg_rate,
    input  logic signed [FREQ_W-1:0] cfg_accel,
    input  logic        [GAIN_W-1:0] cfg_gain,
    input  logic        [TICK_W-1:0] cfg_interval,
    input  logic        [CNT_W-1:0]  cfg_epochs,
    input  logic                     stop,
    output logic                     enable,
    output logic        [FREQ_W-1:0] freq,
    output logic        [GAIN_W-1:0] gain,
    output logic                     busy,
    output logic                     done
);

    doppler_state_t           state;
    doppler_state_t           state_next;
    doppler_cfg_t             cfg;
    logic                     accept;
    logic                     epoch;
    logic                     last;
    logic signed [FREQ_W-1:0] rate;
`ifdef SAT_CHAN_DOPPLER_ACCEL_EN
    logic signed [FREQ_W-1:0] accel;
`else
    logic                     unused_accel;
    assign unused_accel = ^cfg_accel;
`endif

    assign cfg_ready = ((state == IDLE) || (state == HOLD)) && !stop;
    assign accept    = cfg_valid && cfg_ready;
    assign busy      = (state == RAMP);

    // Bundle the offered profile fields.
    always_comb begin
        cfg.freq  = cfg_freq;
        cfg.rate  = cfg_rate;
`ifdef SAT_CHAN_DOPPLER_ACCEL_EN
        cfg.accel = cfg_accel;
`endif
        cfg.gain  = cfg_gain;
    end

    epoch_timer #(
        .TICK_W (TICK_W),
        .CNT_W  (CNT_W)
    ) u_epoch_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .run      (state == RAMP),
        .interval (cfg_interval),
        .epochs   (cfg_epochs),
        .epoch    (epoch),
        .last     (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: stop beats accept, accept beats the final epoch.
    always_comb begin
        state_next = state;
        if (stop)                        state_next = IDLE;
        else if (accept)                 state_next = RAMP;
        else if (state == RAMP && last)  state_next = HOLD;
    end

    // Channel outputs: load on accept, step on each epoch, clear on stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable <= 1'b0;
            freq   <= '0;
            gain   <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                enable <= 1'b0;
                freq   <= '0;
                gain   <= '0;
            end else if (accept) begin
                enable <= 1'b1;
                freq   <= cfg.freq;
                gain   <= cfg.gain;
            end else if (epoch) begin
                freq   <= freq + $unsigned(rate);
                done   <= last;
            end
        end
    end

    // Rate (and accel) registers; the new rate applies from the next epoch.
    always_ff @(posedge clk) begin
        if (accept) begin
            rate  <= cfg.rate;
`ifdef SAT_CHAN_DOPPLER_ACCEL_EN
            accel <= cfg.accel;
`endif
        end
`ifdef SAT_CHAN_DOPPLER_ACCEL_EN
        else if (epoch && !stop) begin
            rate  <= rate + accel;
        end
`endif
    end

endmodule

// File: tb/tb_sat_chan_doppler.sv
// Self-checking bench for sat_chan_doppler with a closed-form ramp model.
module tb_sat_chan_doppler;

`ifdef SAT_CHAN_DOPPLER_ACCEL_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_freq = '0;
    logic [31:0] cfg_rate = '0;
    logic [31:0] cfg_accel = '0;
    logic [15:0] cfg_gain = '0;
    logic [15:0] cfg_interval = '0;
    logic [23:0] cfg_epochs = '0;
    logic        stop = 1'b0;
    logic        enable;
    logic [31:0] freq;
    logic [15:0] gain;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    sat_chan_doppler #(.TICK_W(16), .CNT_W(24)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_freq     (cfg_freq),
        .cfg_rate     (cfg_rate),
        .cfg_accel    (cfg_accel),
        .cfg_gain     (cfg_gain),
        .cfg_interval (cfg_interval),
        .cfg_epochs   (cfg_epochs),
        .stop         (stop),
        .enable       (enable),
        .freq         (freq),
        .gain         (gain),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Frequency k cycles after the profile loads: n = completed epochs.
    function automatic logic [31:0] model_freq(input logic [31:0] f0, input logic [31:0] r0,
                                               input logic [31:0] a, input int ivl,
                                               input int ep, input int k);
        int n;
        logic [31:0] f;
        logic [31:0] r;
        f = f0;
        r = r0;
        n = k / (ivl + 1);
        if (ep != 0 && n > ep) n = ep;
        for (int i = 0; i < n; i++) begin
            f = f + r;
            r = r + (ACC ? a : 32'd0);
        end
        return f;
    endfunction

    function automatic logic model_done(input int ivl, input int ep, input int k);
        return (ep != 0) && (k == ep * (ivl + 1));
    endfunction

    function automatic logic model_busy(input int ivl, input int ep, input int k);
        return (ep == 0) || (k < ep * (ivl + 1));
    endfunction

    // Offer a profile; returns during the first cycle the new outputs are visible.
    task automatic offer(input logic [31:0] f, input logic [31:0] r, input logic [31:0] a,
                         input logic [15:0] g, input int ivl, input int ep);
        @(posedge clk); #1;
        cfg_freq     = f;
        cfg_rate     = r;
        cfg_accel    = a;
        cfg_gain     = g;
        cfg_interval = 16'(ivl);
        cfg_epochs   = 24'(ep);
        cfg_valid    = 1'b1;
        @(posedge clk); #1;
        cfg_valid    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({enable, freq, gain, busy, done} !== 51'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b freq=%h gain=%h busy=%b done=%b expected all 0",
                     enable, freq, gain, busy, done);
        end
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", cfg_ready);
        end
    endtask

    task automatic test_ramp();
        logic [31:0] ef;
        offer(32'h01234567, 32'h100, 32'h0, 16'h4000, 9, 3);
        for (int k = 0; k <= 34; k++) begin
            if (k > 0) @(negedge clk);
            else       @(negedge clk);
            ef = model_freq(32'h01234567, 32'h100, 32'h0, 9, 3, k);
            n_checks++;
            if (freq !== ef || done !== model_done(9, 3, k) || busy !== model_busy(9, 3, k)) begin
                n_fail++;
                $display("FAIL ramp k=%0d: got freq=%h done=%b busy=%b expected freq=%h done=%b busy=%b",
                         k, freq, done, busy, ef, model_done(9, 3, k), model_busy(9, 3, k));
            end
            if (k == 10 || k == 20 || k == 30) begin
                ef = (k == 10) ? 32'h01234667 : (k == 20) ? 32'h01234767 : 32'h01234867;
                n_checks++;
                if (freq !== ef) begin
                    n_fail++;
                    $display("FAIL ramp_step k=%0d: got %h expected %h", k, freq, ef);
                end
            end
            if (k == 30) begin
                n_checks++;
                if (done !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ramp_done: got done=%b busy=%b ready=%b expected 1 0 1",
                             done, busy, cfg_ready);
                end
            end
            if (k == 0 || k == 34) begin
                n_checks++;
                if (enable !== 1'b1 || gain !== 16'h4000) begin
                    n_fail++;
                    $display("FAIL ramp_gain k=%0d: got en=%b gain=%h expected 1 4000", k, enable, gain);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ef;
        offer(32'hFFFFFFF0, 32'h20, 32'h0, 16'h1234, 0, 2);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            ef = model_freq(32'hFFFFFFF0, 32'h20, 32'h0, 0, 2, k);
            n_checks++;
            if (freq !== ef || done !== model_done(0, 2, k)) begin
                n_fail++;
                $display("FAIL wrap k=%0d: got freq=%h done=%b expected freq=%h done=%b",
                         k, freq, done, ef, model_done(0, 2, k));
            end
            if (k == 1) begin
                n_checks++;
                if (freq !== 32'h00000010) begin
                    n_fail++;
                    $display("FAIL wrap_first: got %h expected 00000010", freq);
                end
            end
        end
        offer(32'd100, 32'hFFFFFFFF, 32'h0, 16'h0042, 0, 4);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            ef = (k < 4) ? 32'd100 - 32'(k) : 32'd96;
            n_checks++;
            if (freq !== ef) begin
                n_fail++;
                $display("FAIL negative_rate k=%0d: got %h expected %h", k, freq, ef);
            end
        end
    endtask

    task automatic test_hold_reprogram();
        logic [31:0] ef;
        @(negedge clk);
        n_checks++;
        if (enable !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_state: got en=%b busy=%b ready=%b expected 1 0 1", enable, busy, cfg_ready);
        end
        offer(32'h02468ACE, 32'd7, 32'h0, 16'h0777, 2, 0);
        @(negedge clk);
        n_checks++;
        if (enable !== 1'b1 || freq !== 32'h02468ACE || gain !== 16'h0777) begin
            n_fail++;
            $display("FAIL hold_reload: got en=%b freq=%h gain=%h expected 1 02468ace 0777",
                     enable, freq, gain);
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            ef = model_freq(32'h02468ACE, 32'd7, 32'h0, 2, 0, k);
            n_checks++;
            if (freq !== ef || done !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL forever k=%0d: got freq=%h done=%b busy=%b expected freq=%h done=0 busy=1",
                         k, freq, done, busy, ef);
            end
        end
    endtask

    task automatic test_stop();
        // Still ramping forever from the previous task.
        @(posedge clk); #1;
        stop      = 1'b1;
        cfg_valid = 1'b1;
        cfg_freq  = $urandom;
        cfg_gain  = 16'hBEEF;
        @(negedge clk);
        n_checks++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_ready: got %b expected 0", cfg_ready);
        end
        @(posedge clk); #1;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if ({enable, freq, gain, busy, done} !== 51'd0 || cfg_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stop_idle c=%0d: got en=%b freq=%h gain=%h busy=%b done=%b ready=%b expected 0s ready=1",
                         k, enable, freq, gain, busy, done, cfg_ready);
            end
        end
        // Stop coinciding with the final epoch suppresses done.
        offer(32'd1000, 32'd1, 32'h0, 16'h0001, 0, 3);
        repeat (3) @(negedge clk);
        n_checks++;
        if (freq !== 32'd1002) begin
            n_fail++;
            $display("FAIL stop_pre: got %0d expected 1002", freq);
        end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || freq !== 32'd0 || busy !== 1'b0 || enable !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_last: got done=%b freq=%h busy=%b en=%b expected 0 0 0 0",
                     done, freq, busy, enable);
        end
    endtask

    task automatic test_reset_mid_ramp();
        offer(32'h55555555, 32'h3, 32'h0, 16'h2222, 1, 0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({enable, freq, gain, busy, done} !== 51'd0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_ramp: got en=%b freq=%h gain=%h busy=%b done=%b ready=%b expected 0s ready=1",
                     enable, freq, gain, busy, done, cfg_ready);
        end
    endtask

    task automatic test_random();
        logic [31:0] f0, r0, a0, ef;
        logic [15:0] g0;
        int ivl, ep;
        for (int it = 0; it < 10; it++) begin
            f0  = $urandom;
            r0  = $urandom;
            a0  = $urandom_range(0, 15);
            g0  = 16'($urandom);
            ivl = $urandom_range(0, 3);
            ep  = $urandom_range(1, 5);
            offer(f0, r0, a0, g0, ivl, ep);
            for (int k = 0; k <= ep * (ivl + 1) + 2; k++) begin
                @(negedge clk);
                ef = model_freq(f0, r0, a0, ivl, ep, k);
                n_checks++;
                if (freq !== ef || done !== model_done(ivl, ep, k) || busy !== model_busy(ivl, ep, k)
                    || gain !== g0 || enable !== 1'b1) begin
                    n_fail++;
                    $display("FAIL random it=%0d k=%0d: got freq=%h done=%b busy=%b gain=%h en=%b expected freq=%h done=%b busy=%b gain=%h en=1",
                             it, k, freq, done, busy, gain, enable, ef,
                             model_done(ivl, ep, k), model_busy(ivl, ep, k), g0);
                end
                // Wiggle the profile inputs without a handshake.
                cfg_freq     = $urandom;
                cfg_rate     = $urandom;
                cfg_accel    = $urandom;
                cfg_gain     = 16'($urandom);
                cfg_interval = 16'($urandom);
                cfg_epochs   = 24'($urandom);
            end
        end
    endtask

`ifdef SAT_CHAN_DOPPLER_ACCEL_EN
    task automatic test_accel();
        logic [31:0] seq [6];
        seq = '{32'd0, 32'd0, 32'd1, 32'd3, 32'd6, 32'd10};
        offer(32'd0, 32'd0, 32'd1, 16'h0100, 0, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (freq !== seq[k]) begin
                n_fail++;
                $display("FAIL accel k=%0d: got %0d expected %0d", k, freq, seq[k]);
            end
        end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_ramp();
        test_wrap();
        test_hold_reprogram();
        test_stop();
        test_reset_mid_ramp();
        test_random();
`ifdef SAT_CHAN_DOPPLER_ACCEL_EN
        test_accel();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
